// File: rtl/fft_iter_addr_gen.sv
// rtl/fft_iter_addr_gen.sv - radix-2 DIT FFT butterfly address / twiddle-index generator
// Optional output register stage: define FFT_ADDR_OUT_REG_EN.
module fft_iter_addr_gen #(
   parameter int LAYERS      = 5,
   parameter int BUTTERFLYES = 16,
   parameter int LayWL       = 3,
   parameter int ButtWL      = 4,
   parameter int AddrWL      = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic              ADDR_RST,
   input  logic              ADDR_EN,
   input  logic              LAY_EN,
   output logic [AddrWL-1:0] ADDR_A,
   output logic [AddrWL-1:0] ADDR_B,
   output logic [ButtWL-1:0] TW_ADDR,
   output logic [LayWL-1:0]  LAYER,
   output logic              SEQ_ERR
);

   logic [ButtWL-1:0] b_q, b_d;
   logic [LayWL-1:0]  l_q, l_d;
   logic              err_q, err_d;
   logic              adv, lay;

   logic [AddrWL-1:0] span, low_mask, b_ext;
   logic [AddrWL-1:0] addr_a_c, addr_b_c;
   logic [ButtWL-1:0] tw_c;

   assign adv = EN & ADDR_EN;
   assign lay = EN & LAY_EN;

   always_comb begin
      b_d   = b_q;
      l_d   = l_q;
      err_d = err_q;
      if (ADDR_RST) begin
         b_d   = '0;
         l_d   = '0;
         err_d = 1'b0;
      end else begin
         if (adv)
            b_d = (b_q == ButtWL'(BUTTERFLYES-1)) ? '0 : b_q + 1'b1;
         if (lay) begin
            l_d = (l_q == LayWL'(LAYERS-1)) ? '0 : l_q + 1'b1;
            // a layer step must coincide with the final butterfly's advance
            if (!adv || b_q != ButtWL'(BUTTERFLYES-1))
               err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         b_q   <= '0;
         l_q   <= '0;
         err_q <= 1'b0;
      end else begin
         b_q   <= b_d;
         l_q   <= l_d;
         err_q <= err_d;
      end
   end

   // A is b with a zero inserted at bit l; B sets that bit. Unreachable layers drive 0.
   always_comb begin
      span     = '0;
      low_mask = '0;
      b_ext    = {1'b0, b_q};
      addr_a_c = '0;
      addr_b_c = '0;
      tw_c     = '0;
      if (32'(l_q) < LAYERS) begin
         span     = AddrWL'(1) << l_q;
         low_mask = span - 1'b1;
         addr_a_c = (((b_ext >> l_q) << l_q) << 1) | (b_ext & low_mask);
         addr_b_c = addr_a_c | span;
         tw_c     = ButtWL'((b_ext & low_mask) << (LayWL'(LAYERS-1) - l_q));
      end
   end

`ifdef FFT_ADDR_OUT_REG_EN
   logic [AddrWL-1:0] addr_a_q, addr_b_q;
   logic [ButtWL-1:0] tw_q;
   logic [LayWL-1:0]  layer_q;

   always_ff @(posedge CLK) begin
      if (RST || ADDR_RST) begin
         addr_a_q <= '0;
         addr_b_q <= '0;
         tw_q     <= '0;
         layer_q  <= '0;
      end else begin
         addr_a_q <= addr_a_c;
         addr_b_q <= addr_b_c;
         tw_q     <= tw_c;
         layer_q  <= l_q;
      end
   end

   assign ADDR_A  = addr_a_q;
   assign ADDR_B  = addr_b_q;
   assign TW_ADDR = tw_q;
   assign LAYER   = layer_q;
`else
   assign ADDR_A  = addr_a_c;
   assign ADDR_B  = addr_b_c;
   assign TW_ADDR = tw_c;
   assign LAYER   = l_q;
`endif

   assign SEQ_ERR = err_q;

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// tb/tb_fft_iter_addr_gen.sv - directed and randomized check of fft_iter_addr_gen against an arithmetic model
// Honours FFT_ADDR_OUT_REG_EN for the expected output latency.
module tb_fft_iter_addr_gen;

   localparam int NLAY  = 5;
   localparam int NBUTT = 16;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       EN = 1'b0;
   logic       ADDR_RST = 1'b0;
   logic       ADDR_EN = 1'b0;
   logic       LAY_EN = 1'b0;
   logic [4:0] ADDR_A;
   logic [4:0] ADDR_B;
   logic [3:0] TW_ADDR;
   logic [2:0] LAYER;
   logic       SEQ_ERR;

   int n_chk  = 0;
   int n_fail = 0;

   // reference state: butterfly, layer, error flag
   int m_b = 0, m_l = 0, m_err = 0;
   // expected visible outputs
   int e_a = 0, e_b = 0, e_tw = 0, e_lay = 0;

   fft_iter_addr_gen dut (
      .CLK     (CLK),
      .RST     (RST),
      .EN      (EN),
      .ADDR_RST(ADDR_RST),
      .ADDR_EN (ADDR_EN),
      .LAY_EN  (LAY_EN),
      .ADDR_A  (ADDR_A),
      .ADDR_B  (ADDR_B),
      .TW_ADDR (TW_ADDR),
      .LAYER   (LAYER),
      .SEQ_ERR (SEQ_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // butterfly b of layer l pairs index group*2*span+pos with +span; twiddle k = pos*N/(2*span)
   task automatic ref_addr(input int b, input int l, output int a, output int bb, output int tw);
      int span, grp, pos;
      span = 1 << l;
      grp  = b / span;
      pos  = b % span;
      a    = grp * 2 * span + pos;
      bb   = a + span;
      tw   = pos * (NBUTT / span);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".addr_a"}, int'(ADDR_A), e_a);
      check({tag, ".addr_b"}, int'(ADDR_B), e_b);
      check({tag, ".tw"}, int'(TW_ADDR), e_tw);
      check({tag, ".layer"}, int'(LAYER), e_lay);
      check({tag, ".seq_err"}, int'(SEQ_ERR), m_err);
   endtask

   // called at a negedge; applies inputs for one clock, advances the model, checks at next negedge
   task automatic cyc(input logic rst, input logic arst, input logic en, input logic aen, input logic len,
                      input string tag);
      RST = rst; ADDR_RST = arst; EN = en; ADDR_EN = aen; LAY_EN = len;
      @(posedge CLK);
`ifdef FFT_ADDR_OUT_REG_EN
      if (rst || arst) begin
         e_a = 0; e_b = 0; e_tw = 0; e_lay = 0;
      end else begin
         ref_addr(m_b, m_l, e_a, e_b, e_tw);
         e_lay = m_l;
      end
`endif
      if (rst || arst) begin
         m_b = 0; m_l = 0; m_err = 0;
      end else if (en) begin
         if (len && (!aen || m_b != NBUTT - 1)) m_err = 1;
         if (aen) m_b = (m_b + 1) % NBUTT;
         if (len) m_l = (m_l + 1) % NLAY;
      end
`ifndef FFT_ADDR_OUT_REG_EN
      ref_addr(m_b, m_l, e_a, e_b, e_tw);
      e_lay = m_l;
`endif
      @(negedge CLK);
      check_all(tag);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "idle");
   endtask

   // n butterfly advances, each followed by an idle cycle
   task automatic adv(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "adv");
         idle();
      end
   endtask

   task automatic end_layer();
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "eol");
      idle();
   endtask

   initial begin
      @(negedge CLK);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "arst");
      idle();
      check("init.a", int'(ADDR_A), 0);
      check("init.b", int'(ADDR_B), 1);
      check("init.tw", int'(TW_ADDR), 0);
      check("init.layer", int'(LAYER), 0);
      check("init.err", int'(SEQ_ERR), 0);

      adv(3);
      check("l0b3.a", int'(ADDR_A), 6);
      check("l0b3.b", int'(ADDR_B), 7);
      check("l0b3.tw", int'(TW_ADDR), 0);

      adv(12); end_layer();
      adv(15); end_layer();
      adv(5);
      check("l2b5.a", int'(ADDR_A), 9);
      check("l2b5.b", int'(ADDR_B), 13);
      check("l2b5.tw", int'(TW_ADDR), 4);
      check("l2b5.layer", int'(LAYER), 2);

      adv(10); end_layer();
      adv(15); end_layer();
      adv(15);
      check("l4b15.a", int'(ADDR_A), 15);
      check("l4b15.b", int'(ADDR_B), 31);
      check("l4b15.tw", int'(TW_ADDR), 15);
      check("l4b15.layer", int'(LAYER), 4);
      end_layer();
      check("wrap.layer", int'(LAYER), 0);
      check("wrap.a", int'(ADDR_A), 0);
      check("wrap.err", int'(SEQ_ERR), 0);

      adv(7);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "lay_alone");
      check("seq.err1", int'(SEQ_ERR), 1);
      idle(); idle();
      check("seq.err_held", int'(SEQ_ERR), 1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "arst2");
      idle();
      check("seq.cleared", int'(SEQ_ERR), 0);
      check("seq.a0", int'(ADDR_A), 0);
      check("seq.l0", int'(LAYER), 0);

      adv(2);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "en0");
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "en0");
      end
      check("en0.a", int'(ADDR_A), 4);
      check("en0.err", int'(SEQ_ERR), 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "midrst");
      check("midrst.a", int'(ADDR_A), 0);
      check("midrst.tw", int'(TW_ADDR), 0);
      check("midrst.layer", int'(LAYER), 0);

      for (int i = 0; i < 4000; i++) begin
         int r;
         logic rr, ar, en, aen, len;
         r   = $urandom_range(0, 199);
         rr  = (r == 0);
         ar  = (r >= 1 && r <= 3);
         en  = ($urandom_range(0, 9) != 0);
         aen = ($urandom_range(0, 3) == 0);
         if (aen && m_b == NBUTT - 1)
            len = ($urandom_range(0, 1) == 0);
         else
            len = ($urandom_range(0, 49) == 0);
         cyc(rr, ar, en, aen, len, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
